// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and field widths.
package led_pkg;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePwm   = 2'd3
  } led_mode_e;

  localparam int unsigned PeriodW        = 16;
  localparam int unsigned PwmBitsDefault = 8;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration write channel: valid/ready handshake carrying channel, mode, period and duty.
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned PWM_BITS = PwmBitsDefault
);
  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                CFG_VALID;
  logic                CFG_READY;
  logic [ChW-1:0]      CFG_CH;
  logic [1:0]          CFG_MODE;
  logic [PeriodW-1:0]  CFG_PERIOD;
  logic [PWM_BITS-1:0] CFG_DUTY;

  modport master (
    output CFG_VALID, CFG_CH, CFG_MODE, CFG_PERIOD, CFG_DUTY,
    input  CFG_READY
  );

  modport slave (
    input  CFG_VALID, CFG_CH, CFG_MODE, CFG_PERIOD, CFG_DUTY,
    output CFG_READY
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: holds mode/period/duty, runs the blink counter and phase, drives a
// registered LED bit.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PwmBitsDefault
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick,
  input  logic                wr_en,
  input  logic [1:0]          wr_mode,
  input  logic [PeriodW-1:0]  wr_period,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  led_mode_e           mode_q, mode_d;
  logic [PeriodW-1:0]  period_q, period_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PeriodW-1:0]  cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                led_q, led_d;
  logic [PeriodW-1:0]  cnt_last;

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    // A period of zero behaves as one tick per half-period.
    cnt_last = (period_q == '0) ? '0 : period_q - 1'b1;

    // A write wins over a coincident tick.
    if (wr_en) begin
      mode_d   = led_mode_e'(wr_mode);
      period_d = wr_period;
      duty_d   = wr_duty;
      cnt_d    = '0;
      phase_d  = 1'b0;
    end else if (tick && (mode_q == ModeBlink)) begin
      if (cnt_q == cnt_last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (mode_q)
      ModeOff:   led_d = 1'b0;
      ModeOn:    led_d = 1'b1;
      ModeBlink: led_d = phase_q;
      ModePwm:   led_d = (pwm_cnt < duty_q);
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q   <= ModeOff;
      period_q <= PeriodW'(1);
      duty_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter, config
// handshake with a one-cycle commit gap, and one led_channel per output.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned PWM_BITS = PwmBitsDefault
) (
  input  logic            CLK,
  input  logic            RST,
  led_pattern_gen_if.slave cfg,
  output logic [N_CH-1:0] LED
);

  localparam int unsigned Div    = CLK_HZ / TICK_HZ;
  localparam int unsigned PrescW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned ChW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PrescW-1:0]   presc_q, presc_d;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                ready_q, ready_d;
  logic                accept;

  always_comb begin
    tick    = (presc_q == PrescW'(Div - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;
    accept  = cfg.CFG_VALID & ready_q;
    // Ready drops for the commit cycle following every accept.
    ready_d = ~accept;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      pwm_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      ready_q <= ready_d;
    end
  end

  assign cfg.CFG_READY = ready_q;

  // Out-of-range channel numbers match no instance and are silently dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .CLK       (CLK),
      .RST       (RST),
      .tick      (tick),
      .wr_en     (accept && (cfg.CFG_CH == ChW'(g))),
      .wr_mode   (cfg.CFG_MODE),
      .wr_period (cfg.CFG_PERIOD),
      .wr_duty   (cfg.CFG_DUTY),
      .pwm_cnt   (pwm_q),
      .led       (LED[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: 100 Hz tick from 1 kHz clock, two channels, 4-bit PWM,
// plus a three-channel instance to exercise an out-of-range channel number.
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int unsigned ClkHz   = 1000;
  localparam int unsigned TickHz  = 100;
  localparam int unsigned NCh     = 2;
  localparam int unsigned PwmBits = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] led;
  logic [2:0] led3;
  int         total = 0;
  int         bad   = 0;
  int         cyc;

  always #5 clk = ~clk;

  // Rising edges since reset release; ticks are consumed on edges 10, 20, 30, ...
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  led_pattern_gen_if #(.N_CH(NCh), .PWM_BITS(PwmBits)) cfg ();
  led_pattern_gen_if #(.N_CH(3),   .PWM_BITS(PwmBits)) cfg3 ();

  led_pattern_gen #(
    .CLK_HZ   (ClkHz),
    .TICK_HZ  (TickHz),
    .N_CH     (NCh),
    .PWM_BITS (PwmBits)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .cfg (cfg),
    .LED (led)
  );

  led_pattern_gen #(
    .CLK_HZ   (ClkHz),
    .TICK_HZ  (TickHz),
    .N_CH     (3),
    .PWM_BITS (PwmBits)
  ) dut3 (
    .CLK (clk),
    .RST (rst),
    .cfg (cfg3),
    .LED (led3)
  );

  task automatic write(input int ch, input logic [1:0] mode, input int period, input int duty,
                       output int w);
    int n = 0;
    @(negedge clk);
    cfg.CFG_CH     = 1'(ch);
    cfg.CFG_MODE   = mode;
    cfg.CFG_PERIOD = 16'(period);
    cfg.CFG_DUTY   = 4'(duty);
    cfg.CFG_VALID  = 1'b1;
    while (!cfg.CFG_READY && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cfg.CFG_READY !== 1'b1) begin
      bad++;
      $display("FAIL write_ready: ready=%b required 1", cfg.CFG_READY);
    end
    @(posedge clk);
    #1;
    w = cyc;
    cfg.CFG_VALID = 1'b0;
  endtask

  task automatic test_reset();
    int nz = 0;
    repeat (3) @(negedge clk);
    total++;
    if (led !== 2'b00) begin
      bad++; $display("FAIL reset_led: led=%b required 00", led);
    end
    total++;
    if (cfg.CFG_READY !== 1'b0) begin
      bad++; $display("FAIL reset_ready: ready=%b required 0", cfg.CFG_READY);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cfg.CFG_READY !== 1'b1) begin
      bad++; $display("FAIL ready_after_release: ready=%b required 1", cfg.CFG_READY);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (led !== 2'b00) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++; $display("FAIL idle_led: nonzero samples=%0d required 0", nz);
    end
  endtask

  task automatic test_blink();
    int w, f, nt = 0, l1bad = 0;
    int t[3];
    logic prev = 1'b0;
    t = '{-1, -1, -1};
    write(0, ModeBlink, 3, 0, w);
    f = (w / 10 + 3) * 10 + 1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (led[0] !== prev) begin
        if (nt < 3) t[nt] = cyc;
        nt++;
        prev = led[0];
      end
      if (led[1] !== 1'b0) l1bad++;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (t[i] != f + 30 * i) begin
        bad++; $display("FAIL blink3_toggle%0d: edge=%0d required %0d", i, t[i], f + 30 * i);
      end
    end
    total++;
    if (l1bad != 0) begin
      bad++; $display("FAIL blink3_other_ch: led1 high samples=%0d required 0", l1bad);
    end
  endtask

  task automatic test_pwm();
    int w, hi;
    int duties[3] = '{4, 0, 15};
    for (int d = 0; d < 3; d++) begin
      write(1, ModePwm, 0, duties[d], w);
      repeat (3) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (led[1] === 1'b1) hi++;
      end
      total++;
      if (hi != duties[d]) begin
        bad++; $display("FAIL pwm_duty%0d: high=%0d of 16 required %0d", duties[d], hi,
                        duties[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int        idx = 0;
    int        chs[4]   = '{0, 1, 0, 1};
    logic [1:0] modes[4] = '{ModeOff, ModeOn, ModeOn, ModeOff};
    @(negedge clk);
    cfg.CFG_PERIOD = 16'd1;
    cfg.CFG_DUTY   = 4'd0;
    cfg.CFG_VALID  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (idx < 4) begin
        cfg.CFG_CH   = 1'(chs[idx]);
        cfg.CFG_MODE = modes[idx];
      end
      total++;
      if (cfg.CFG_READY !== ((k % 2) == 0)) begin
        bad++; $display("FAIL b2b_ready%0d: ready=%b required %b", k, cfg.CFG_READY,
                        (k % 2) == 0);
      end
      if (cfg.CFG_READY === 1'b1) idx++;
      @(negedge clk);
    end
    cfg.CFG_VALID = 1'b0;
    total++;
    if (idx != 4) begin
      bad++; $display("FAIL b2b_accepts: accepts=%0d required 4", idx);
    end
    repeat (2) @(negedge clk);
    total++;
    if (led !== 2'b01) begin
      bad++; $display("FAIL b2b_led: led=%b required 01", led);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    cfg3.CFG_CH    = 2'd3;
    cfg3.CFG_MODE  = ModeOn;
    cfg3.CFG_VALID = 1'b1;
    total++;
    if (cfg3.CFG_READY !== 1'b1) begin
      bad++; $display("FAIL oor_ready: ready=%b required 1", cfg3.CFG_READY);
    end
    @(negedge clk);
    cfg3.CFG_VALID = 1'b0;
    total++;
    if (cfg3.CFG_READY !== 1'b0) begin
      bad++; $display("FAIL oor_commit: ready=%b required 0", cfg3.CFG_READY);
    end
    repeat (3) @(negedge clk);
    total++;
    if (led3 !== 3'b000) begin
      bad++; $display("FAIL oor_led: led=%b required 000", led3);
    end
    cfg3.CFG_CH    = 2'd2;
    cfg3.CFG_VALID = 1'b1;
    @(negedge clk);
    cfg3.CFG_VALID = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (led3 !== 3'b100) begin
      bad++; $display("FAIL ch2_on_led: led=%b required 100", led3);
    end
  endtask

  task automatic test_blink_zero();
    int w, f, n = 0, nt = 0;
    int t[3];
    logic prev;
    t = '{-1, -1, -1};
    // Align so the accept edge coincides with a tick edge.
    while ((cyc % 10) != 8 && n < 12) begin
      @(negedge clk);
      n++;
    end
    write(0, ModeBlink, 0, 0, w);
    f = (w / 10 + 1) * 10 + 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (led[0] !== 1'b0) begin
      bad++; $display("FAIL blink0_start: led0=%b required 0", led[0]);
    end
    prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (led[0] !== prev) begin
        if (nt < 3) t[nt] = cyc;
        nt++;
        prev = led[0];
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (t[i] != f + 10 * i) begin
        bad++; $display("FAIL blink0_toggle%0d: edge=%0d required %0d", i, t[i], f + 10 * i);
      end
    end
    // Catch a fresh rise so phase is known to be 1 for several more cycles.
    n = 0;
    while (led[0] !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    while (led[0] !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    total++;
    if (led[0] !== 1'b1) begin
      bad++; $display("FAIL blink0_rise: led0=%b required 1", led[0]);
    end
    write(0, ModeBlink, 0, 0, w);
    f = (w / 10 + 1) * 10 + 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (led[0] !== 1'b0) begin
      bad++; $display("FAIL rewrite_phase: led0=%b required 0", led[0]);
    end
    n = 0;
    while (led[0] === 1'b0 && n < 30) begin @(negedge clk); n++; end
    total++;
    if (cyc != f) begin
      bad++; $display("FAIL rewrite_restart: toggle edge=%0d required %0d", cyc, f);
    end
  endtask

  task automatic test_reset_mid();
    int w, nz = 0;
    write(1, ModeOn, 0, 0, w);
    repeat (2) @(negedge clk);
    total++;
    if (led[1] !== 1'b1) begin
      bad++; $display("FAIL pre_reset_led1: led1=%b required 1", led[1]);
    end
    write(1, ModeOn, 0, 0, w);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (led !== 2'b00) begin
      bad++; $display("FAIL async_reset_led: led=%b required 00", led);
    end
    total++;
    if (cfg.CFG_READY !== 1'b0) begin
      bad++; $display("FAIL async_reset_ready: ready=%b required 0", cfg.CFG_READY);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cfg.CFG_READY !== 1'b1) begin
      bad++; $display("FAIL resume_ready: ready=%b required 1", cfg.CFG_READY);
    end
    write(1, ModeOn, 0, 0, w);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k > 0 && led !== 2'b10) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++; $display("FAIL resume_led: bad samples=%0d required led=10", nz);
    end
  endtask

  initial begin
    rst             = 1'b1;
    cfg.CFG_VALID   = 1'b0;
    cfg.CFG_CH      = '0;
    cfg.CFG_MODE    = '0;
    cfg.CFG_PERIOD  = '0;
    cfg.CFG_DUTY    = '0;
    cfg3.CFG_VALID  = 1'b0;
    cfg3.CFG_CH     = '0;
    cfg3.CFG_MODE   = '0;
    cfg3.CFG_PERIOD = '0;
    cfg3.CFG_DUTY   = '0;
    test_reset();
    test_blink();
    test_pwm();
    test_back_to_back();
    test_out_of_range();
    test_blink_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have the parameter CLK_HZ, default 100000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have the parameter TICK_HZ, default 1000, meaning the blink timebase tick rate in Hz; CLK_HZ SHALL be an integer multiple of TICK_HZ.
REQ-003 The block SHALL have the parameter N_CH, default 2, meaning the number of LED channels (1..16).
REQ-004 The block SHALL have the parameter PWM_BITS, default 8, meaning the PWM counter and duty width.
REQ-005 The block SHALL have the port CLK, input, 1 bit: the single clock; all state SHALL be on the rising edge.
REQ-006 The block SHALL have the port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port CFG_VALID, input, 1 bit: a configuration write is offered.
REQ-008 The block SHALL have the port CFG_READY, output, 1 bit: the block can accept a write.
REQ-009 The block SHALL have the port CFG_CH, input, max(1,clog2(N_CH)) bits: target channel.
REQ-010 The block SHALL have the port CFG_MODE, input, 2 bits: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 The block SHALL have the port CFG_PERIOD, input, 16 bits: BLINK half-period in ticks.
REQ-012 The block SHALL have the port CFG_DUTY, input, PWM_BITS bits: PWM on-count.
REQ-013 The block SHALL have the port LED, output, N_CH bits: registered channel outputs.

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1, wrap to 0, and assert internal tick for exactly the one cycle where it equals the terminal value.
REQ-015 Shared PWM counter SHALL increment every clock, PWM_BITS wide, wrapping from all-ones to 0.
REQ-016 Write accepted on an edge with CFG_VALID=1 and CFG_READY=1; channel mode/period/duty SHALL update on that edge.
REQ-017 CFG_READY SHALL deassert for exactly one cycle after each accept (commit cycle), then reassert; back-to-back accepts therefore occur at most every 2 cycles.
REQ-018 A CFG_CH value >= N_CH SHALL be accepted (handshake completes) and ignored.
REQ-019 Any accepted write SHALL clear the target channel's tick counter and blink phase to 0.
REQ-020 OFF: LED[i]=0; ON: LED[i]=1.
REQ-021 BLINK: on each tick, if channel tick counter == max(CFG_PERIOD,1)-1, the counter SHALL clear and phase toggle; else counter increments; LED[i]=phase; CFG_PERIOD=0 SHALL behave as 1.
REQ-022 PWM: LED[i] SHALL be 1 when PWM counter < duty; duty 0 gives constant 0; duty all-ones gives 1 for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-023 LED SHALL be registered: LED reflects channel state one edge after that state changes (write at edge E -> LED valid after E+1).
REQ-024 A write coinciding with a tick for the same channel: the write SHALL win and the tick SHALL be discarded for that channel.
REQ-025 Channels not targeted by a write SHALL be unaffected by it.

Reset
REQ-026 While RST=1: all modes OFF, period 1, duty 0, counters and phases 0, LED=0, CFG_READY=0.
REQ-027 CFG_READY SHALL be 1 from the first rising edge after RST deasserts; RST asserted mid-operation SHALL abort any commit cycle immediately.

Structure
REQ-028 Mode encodings, the 16-bit period width and the default PWM_BITS SHALL live in shared package led_pkg.
REQ-029 Per-channel state SHALL be one sub-module, led_channel, instantiated N_CH times by generate; the prescaler, PWM counter and handshake SHALL live at the top level.

Verification (CLK_HZ=1000, TICK_HZ=100: tick every 10 clocks; N_CH=2, PWM_BITS=4)
REQ-030 Reset released, no writes -> LED=00 indefinitely; CFG_READY=1 one edge after release.
REQ-031 Write ch0 BLINK period 3 -> LED[0] toggles every 30 clocks, first toggle 3 ticks after the write; LED[1] stays 0.
REQ-032 Write ch1 PWM duty 4 -> LED[1] high 4 of every 16 clocks; duty 0 -> always 0; duty 15 -> high 15 of 16.
REQ-033 CFG_VALID held high for 4 writes -> accepts on alternating cycles only; CFG_CH=3 write -> handshake completes, LED unchanged.
REQ-034 BLINK period 0 -> toggles every tick (10 clocks); rewrite to BLINK while phase=1 -> LED[0]=0 one edge later, counter restarted.
REQ-035 RST pulsed during a commit cycle with BLINK running -> LED=00 and CFG_READY=0 asynchronously; normal accept resumes after release.
